// File: rtl/ahb_slave_port_ctrl.sv
// Per-slave AHB port sequencer: burst-locked address select, pipelined data select, beat counting.
// Optional stalled-slave watchdog enabled by defining AHB_PORT_WAIT_TIMEOUT_EN.
module ahb_slave_port_ctrl #(
   parameter int MASTER_NUM     = 2,
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic                    hclk,
   input  logic                    hreset_n,
   input  logic [MASTER_NUM-1:0]   hgrant_in,
   input  logic [MASTER_NUM*2-1:0] htrans_in,
   input  logic [MASTER_NUM*3-1:0] hburst_in,
   input  logic                    hready_slv,
   input  logic                    hresp_slv,
   output logic [MASTER_NUM-1:0]   addr_sel,
   output logic [MASTER_NUM-1:0]   data_sel,
   output logic [MASTER_NUM-1:0]   hready_out,
   output logic [MASTER_NUM-1:0]   hresp_out,
   output logic                    burst_done,
   output logic                    burst_abort,
   output logic                    busy
);

   // state | meaning
   // IDLE  | no burst owned; address select follows the arbiter grant
   // BURST | owner locked, beats remain to be issued
   // LAST  | final beat issued, waiting for its data phase to complete
   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_BURST = 2'd1;
   localparam logic [1:0] ST_LAST  = 2'd2;

   localparam logic [1:0] HT_IDLE   = 2'b00;
   localparam logic [1:0] HT_NONSEQ = 2'b10;
   localparam logic [1:0] HT_SEQ    = 2'b11;

   localparam logic [2:0] HB_SINGLE = 3'b000;
   localparam logic [2:0] HB_INCR   = 3'b001;

   logic [1:0]            state_q, state_d;
   logic [4:0]            cnt_q, cnt_d;
   logic [MASTER_NUM-1:0] owner_q, owner_d;
   logic                  incr_q, incr_d;
   logic                  single_q, single_d;
   logic                  done_d, abort_d;

   logic [MASTER_NUM-1:0] grant_sel;
   logic [1:0]            own_trans;
   logic [2:0]            own_burst;
   logic [4:0]            len_m1;
   logic                  eff_ready, eff_resp, to_ovr, to_end;
   logic                  accept, err;

   always_comb begin
      grant_sel = '0;
      for (int i = MASTER_NUM-1; i >= 0; i--) begin
         if (hgrant_in[i]) begin
            grant_sel    = '0;
            grant_sel[i] = 1'b1;
         end
      end
   end

   // Grant is ignored while a burst is locked; nothing is selected while in reset.
   assign addr_sel = !hreset_n ? '0 : (state_q == ST_BURST) ? owner_q : grant_sel;

   always_comb begin
      own_trans = HT_IDLE;
      own_burst = HB_SINGLE;
      for (int i = 0; i < MASTER_NUM; i++) begin
         if (addr_sel[i]) begin
            own_trans = htrans_in[2*i +: 2];
            own_burst = hburst_in[3*i +: 3];
         end
      end
   end

   always_comb begin
      case (own_burst)
         3'b010, 3'b011: len_m1 = 5'd3;
         3'b100, 3'b101: len_m1 = 5'd7;
         3'b110, 3'b111: len_m1 = 5'd15;
         default:        len_m1 = 5'd0;
      endcase
   end

`ifdef AHB_PORT_WAIT_TIMEOUT_EN
   logic [7:0] to_cnt_q;
   logic       to_ph1_q, to_ph2_q;
   logic       stall;

   assign stall = (|data_sel) & ~hready_slv & ~to_ph1_q & ~to_ph2_q;

   always_ff @(posedge hclk or negedge hreset_n) begin
      if (!hreset_n) begin
         to_cnt_q <= '0;
         to_ph1_q <= 1'b0;
         to_ph2_q <= 1'b0;
      end else begin
         to_ph2_q <= to_ph1_q;
         to_ph1_q <= stall && (to_cnt_q == 8'(TIMEOUT_CYCLES-1));
         if (stall && (to_cnt_q != 8'(TIMEOUT_CYCLES-1)))
            to_cnt_q <= to_cnt_q + 8'd1;
         else
            to_cnt_q <= '0;
      end
   end

   // Two-cycle ERROR forced onto the owner in place of the stalled slave.
   assign to_ovr    = to_ph1_q | to_ph2_q;
   assign to_end    = to_ph2_q;
   assign eff_ready = to_ph2_q | (~to_ph1_q & hready_slv);
   assign eff_resp  = to_ovr | hresp_slv;
`else
   logic [7:0] to_unused;
   assign to_unused = 8'(TIMEOUT_CYCLES);
   assign to_ovr    = 1'b0;
   assign to_end    = 1'b0;
   assign eff_ready = hready_slv;
   assign eff_resp  = hresp_slv;
`endif

   assign accept = hready_slv & ~to_ovr;
   assign err    = (|data_sel) & eff_ready & eff_resp;

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      owner_d  = owner_q;
      incr_d   = incr_q;
      single_d = single_q;
      done_d   = 1'b0;
      abort_d  = 1'b0;
      if (err) begin
         state_d  = ST_IDLE;
         cnt_d    = '0;
         owner_d  = '0;
         incr_d   = 1'b0;
         single_d = 1'b0;
         abort_d  = 1'b1;
      end else if (accept) begin
         single_d = 1'b0;
         if (single_q && !eff_resp)
            done_d = 1'b1;
         case (state_q)
            ST_BURST: begin
               if (own_trans == HT_SEQ) begin
                  if (!incr_q && cnt_q == 5'd1)
                     state_d = ST_LAST;
                  if (cnt_q != 5'd0)
                     cnt_d = cnt_q - 5'd1;
               end else if (incr_q && (own_trans == HT_IDLE || own_trans == HT_NONSEQ)) begin
                  state_d = ST_LAST;
               end
            end
            default: begin
               if (state_q == ST_LAST && !eff_resp) begin
                  state_d = ST_IDLE;
                  done_d  = 1'b1;
                  owner_d = '0;
                  incr_d  = 1'b0;
               end
               // A NONSEQ alongside the LAST completion starts the next transfer directly.
               if (state_d == ST_IDLE && own_trans == HT_NONSEQ) begin
                  cnt_d = len_m1;
                  if (own_burst == HB_SINGLE) begin
                     single_d = 1'b1;
                  end else begin
                     state_d = ST_BURST;
                     owner_d = addr_sel;
                     incr_d  = (own_burst == HB_INCR);
                  end
               end
            end
         endcase
      end
   end

   always_ff @(posedge hclk or negedge hreset_n) begin
      if (!hreset_n) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         owner_q     <= '0;
         incr_q      <= 1'b0;
         single_q    <= 1'b0;
         data_sel    <= '0;
         burst_done  <= 1'b0;
         burst_abort <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         owner_q     <= owner_d;
         incr_q      <= incr_d;
         single_q    <= single_d;
         burst_done  <= done_d;
         burst_abort <= abort_d;
         if (to_end)
            data_sel <= '0;
         else if (accept)
            data_sel <= addr_sel & {MASTER_NUM{own_trans[1]}};
      end
   end

   always_comb begin
      hready_out = '1;
      hresp_out  = '0;
      for (int i = 0; i < MASTER_NUM; i++) begin
         hready_out[i] = data_sel[i] ? eff_ready : 1'b1;
         hresp_out[i]  = data_sel[i] & eff_resp;
      end
   end

   assign busy = (state_q != ST_IDLE) | (|data_sel);

endmodule
